// File: rtl/alu_mdu_unit.sv
// ALU with iterative shift-add multiplier and optional signed restoring divider.
// Define ALU_MDU_DIV_EN to build the DIV state and datapath; otherwise DIV decodes as illegal.
module alu_mdu_unit #(
  parameter int XLEN   = 32,
  parameter int IMM_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [3:0]      alu_ctrl,
  output logic            illegal
);

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_DIV = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_MUL = 4'b0011;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_OR  = 4'b1000;
  localparam logic [3:0] C_XOR = 4'b1110;
  localparam logic [3:0] C_ILL = 4'b1111;
  localparam int         CW    = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
`ifdef ALU_MDU_DIV_EN
    S_DIV,
`endif
    S_DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [3:0]      dec;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] acc, mcand, mplier, acc_nxt;
  logic            last;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign last      = (cnt == CW'(XLEN - 1));
  assign acc_nxt   = mplier[0] ? acc + mcand : acc;

  always_comb begin
    dec = C_ILL;
    if (opcode == OPC_R) begin
      case ({func3, func7})
        10'b000_0000000: dec = C_ADD;
        10'b000_0100000: dec = C_SUB;
        10'b000_0000001: dec = C_MUL;
        10'b010_0000000: dec = C_SLT;
        10'b100_0000000: dec = C_XOR;
`ifdef ALU_MDU_DIV_EN
        10'b100_0000001: dec = C_DIV;
`endif
        10'b110_0000000: dec = C_OR;
        10'b111_0000000: dec = C_AND;
        default:         dec = C_ILL;
      endcase
    end else if (opcode == OPC_I && IMM_EN != 0) begin
      case (func3)
        3'b000:  dec = C_ADD;
        3'b010:  dec = C_SLT;
        3'b100:  dec = C_XOR;
        3'b110:  dec = C_OR;
        3'b111:  dec = C_AND;
        default: dec = C_ILL;
      endcase
    end
  end

  always_comb begin
    alu_res = '0;
    case (dec)
      C_ADD:   alu_res = op_a + op_b;
      C_SUB:   alu_res = op_a - op_b;
      C_AND:   alu_res = op_a & op_b;
      C_OR:    alu_res = op_a | op_b;
      C_XOR:   alu_res = op_a ^ op_b;
      C_SLT:   alu_res = XLEN'($signed(op_a) < $signed(op_b));
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MDU_DIV_EN
  // Divide magnitudes, then fix the quotient sign; most-negative / -1 falls out naturally.
  logic [XLEN-1:0] quot, dvsr, q_fin;
  logic [XLEN:0]   rem, rem_sh, rem_nxt;
  logic            neg, dbz, qbit;

  assign rem_sh  = {rem[XLEN-1:0], quot[XLEN-1]};
  assign qbit    = (rem_sh >= {1'b0, dvsr});
  assign rem_nxt = qbit ? rem_sh - {1'b0, dvsr} : rem_sh;
  assign q_fin   = {quot[XLEN-2:0], qbit};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      result   <= '0;
      alu_ctrl <= '0;
      illegal  <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
`ifdef ALU_MDU_DIV_EN
      quot     <= '0;
      dvsr     <= '0;
      rem      <= '0;
      neg      <= 1'b0;
      dbz      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          alu_ctrl <= dec;
          illegal  <= (dec == C_ILL);
          cnt      <= '0;
          case (dec)
            C_MUL: begin
              acc    <= '0;
              mcand  <= op_a;
              mplier <= op_b;
              state  <= S_MUL;
            end
`ifdef ALU_MDU_DIV_EN
            C_DIV: begin
              quot  <= op_a[XLEN-1] ? -op_a : op_a;
              dvsr  <= op_b[XLEN-1] ? -op_b : op_b;
              rem   <= '0;
              neg   <= op_a[XLEN-1] ^ op_b[XLEN-1];
              dbz   <= (op_b == '0);
              state <= S_DIV;
            end
`endif
            default: begin
              result <= alu_res;
              state  <= S_DONE;
            end
          endcase
        end
        S_MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (last) begin
            result <= acc_nxt;
            state  <= S_DONE;
          end
        end
`ifdef ALU_MDU_DIV_EN
        S_DIV: begin
          rem  <= rem_nxt;
          quot <= q_fin;
          cnt  <= cnt + 1'b1;
          if (last) begin
            result <= dbz ? '1 : (neg ? -q_fin : q_fin);
            state  <= S_DONE;
          end
        end
`endif
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu_unit.sv
// Directed table-driven bench for alu_mdu_unit (XLEN=32) plus hold, busy-ignore and reset-abort sequences.
module tb_alu_mdu_unit;
  localparam logic [6:0] R = 7'b0110011;
  localparam logic [6:0] I = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [6:0]  opcode, func7;
  logic [2:0]  func3;
  logic [31:0] op_a, op_b, result;
  logic [3:0]  alu_ctrl;

  int total = 0;
  int bad   = 0;

  alu_mdu_unit #(.XLEN(32), .IMM_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .func3(func3), .func7(func7), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .alu_ctrl(alu_ctrl), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b, res;
    logic [3:0]  ctrl;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait (bounded) for out_valid; leaves the unit in DONE.
  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, output int lat);
    opcode = opc; func3 = f3; func7 = f7; op_a = a; op_b = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      step();
      lat++;
    end
  endtask

  task automatic release_done();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [31:0] hold_res;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; func3 = '0; func7 = '0; op_a = '0; op_b = '0;
    step(); step();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_alu_ctrl", alu_ctrl, 0);
    check("rst_illegal", illegal, 0);
    rst = 1'b0;
    step();

    vecs.push_back('{R, 3'b000, 7'h00, 32'hFFFFFFFF, 32'h1,        32'h0,        4'b0010, 1'b0, 1});
    vecs.push_back('{I, 3'b010, 7'h00, 32'hFFFFFFFE, 32'h3,        32'h1,        4'b0111, 1'b0, 1});
    vecs.push_back('{R, 3'b000, 7'h01, 32'h00010003, 32'h00020005, 32'h000B000F, 4'b0011, 1'b0, 33});
    vecs.push_back('{R, 3'b000, 7'h20, 32'h5,        32'h7,        32'hFFFFFFFE, 4'b0110, 1'b0, 1});
    vecs.push_back('{R, 3'b111, 7'h00, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0000, 1'b0, 1});
    vecs.push_back('{R, 3'b110, 7'h00, 32'hF0000000, 32'h0000000F, 32'hF000000F, 4'b1000, 1'b0, 1});
    vecs.push_back('{R, 3'b100, 7'h00, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 4'b1110, 1'b0, 1});
    vecs.push_back('{R, 3'b010, 7'h00, 32'h3,        32'hFFFFFFFE, 32'h0,        4'b0111, 1'b0, 1});
    vecs.push_back('{I, 3'b000, 7'h7F, 32'h0000000A, 32'hFFFFFFFF, 32'h9,        4'b0010, 1'b0, 1});
    vecs.push_back('{I, 3'b111, 7'h20, 32'h12345678, 32'h0000FF00, 32'h00005600, 4'b0000, 1'b0, 1});
    vecs.push_back('{I, 3'b001, 7'h00, 32'h1,        32'h1,        32'h0,        4'b1111, 1'b1, 1});
    vecs.push_back('{7'b0110111, 3'b000, 7'h00, 32'h1, 32'h1,      32'h0,        4'b1111, 1'b1, 1});
    vecs.push_back('{R, 3'b111, 7'h01, 32'h1,        32'h1,        32'h0,        4'b1111, 1'b1, 1});
    vecs.push_back('{R, 3'b000, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        4'b0011, 1'b0, 33});
`ifdef ALU_MDU_DIV_EN
    vecs.push_back('{R, 3'b100, 7'h01, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 4'b0001, 1'b0, 33});
    vecs.push_back('{R, 3'b100, 7'h01, 32'h5,        32'h0,        32'hFFFFFFFF, 4'b0001, 1'b0, 33});
    vecs.push_back('{R, 3'b100, 7'h01, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b0001, 1'b0, 33});
    vecs.push_back('{R, 3'b100, 7'h01, 32'h64,       32'h7,        32'hE,        4'b0001, 1'b0, 33});
`else
    vecs.push_back('{R, 3'b100, 7'h01, 32'hFFFFFFF9, 32'h2,        32'h0,        4'b1111, 1'b1, 1});
`endif

    foreach (vecs[i]) begin
      check($sformatf("v%0d_in_ready", i), in_ready, 1);
      issue(vecs[i].opc, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_result", i), result, vecs[i].res);
      check($sformatf("v%0d_alu_ctrl", i), alu_ctrl, vecs[i].ctrl);
      check($sformatf("v%0d_illegal", i), illegal, vecs[i].ill);
      release_done();
    end

    // Illegal result held for 5 cycles with a competing request that must be ignored.
    issue(R, 3'b000, 7'h21, 32'h11, 32'h22, lat);
    check("hold_latency", lat, 1);
    opcode = R; func3 = 3'b000; func7 = 7'h00; op_a = 32'h7; op_b = 32'h8;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_result", result, 0);
      check("hold_alu_ctrl", alu_ctrl, 4'b1111);
      check("hold_illegal", illegal, 1);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("post_ack_out_valid", out_valid, 0);
    check("post_ack_in_ready", in_ready, 1);
    step();
    check("post_ack_idle", out_valid, 0);

    // Request during MUL iteration is ignored and does not stretch the latency.
    opcode = R; func3 = 3'b000; func7 = 7'h01; op_a = 32'h0000_0007; op_b = 32'h0000_0006;
    in_valid = 1'b1;
    step();
    opcode = R; func3 = 3'b000; func7 = 7'h00; op_a = 32'h1; op_b = 32'h1;
    lat = 1;
    while (!out_valid && lat < 200) begin
      step();
      lat++;
    end
    in_valid = 1'b0;
    check("busy_mul_latency", lat, 33);
    check("busy_mul_result", result, 32'h2A);
    check("busy_mul_ctrl", alu_ctrl, 4'b0011);
    release_done();

    // Reset 10 cycles into a MUL aborts it; the product must never appear.
    opcode = R; func3 = 3'b000; func7 = 7'h01; op_a = 32'h3; op_b = 32'h5;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_result", result, 0);
    check("abort_alu_ctrl", alu_ctrl, 0);
    lat = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) lat++;
      step();
    end
    check("abort_never_valid", lat, 0);
    issue(R, 3'b000, 7'h00, 32'h10, 32'h20, lat);
    check("after_abort_latency", lat, 1);
    check("after_abort_result", result, 32'h30);
    check("after_abort_ctrl", alu_ctrl, 4'b0010);
    release_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/alu_mdu_unit.md
ALU_MDU_UNIT -- requirements
Module: alu_mdu_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 8..64.
REQ-002 Parameter IMM_EN, default 1; 1 = decode I-type opcode 7'b0010011, 0 = I-type reported illegal.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 in_valid  in  1  request present.
REQ-006 in_ready  out  1  unit can accept; high only in IDLE.
REQ-007 opcode  in  7  instruction opcode; R-type 7'b0110011, I-type 7'b0010011.
REQ-008 func3  in  3  instruction func3.
REQ-009 func7  in  7  instruction func7; ignored for I-type.
REQ-010 op_a  in  XLEN  operand A, rs1.
REQ-011 op_b  in  XLEN  operand B, rs2 or sign-extended immediate.
REQ-012 out_valid  out  1  result available.
REQ-013 out_ready  in  1  consumer accepts result.
REQ-014 result  out  XLEN  operation result.
REQ-015 alu_ctrl  out  4  decoded control code of the current operation.
REQ-016 illegal  out  1  current operation did not decode.

Function
REQ-017 Control codes: AND 0000, DIV 0001, ADD 0010, MUL 0011, SUB 0110, SLT 0111, OR 1000, XOR 1110, illegal 1111.
REQ-018 R-type decode {func3,func7}: 000/0000000 ADD; 000/0100000 SUB; 000/0000001 MUL; 010/0000000 SLT; 100/0000000 XOR; 100/0000001 DIV; 110/0000000 OR; 111/0000000 AND; anything else illegal.
REQ-019 I-type decode by func3: 000 ADD, 010 SLT, 100 XOR, 110 OR, 111 AND; others illegal.
REQ-020 Any other opcode is illegal.
REQ-021 States: IDLE, MUL, DIV, DONE; handshake on in_valid&in_ready captures opcode, func3, func7, op_a, op_b.
REQ-022 IDLE + handshake: ADD/SUB/AND/OR/XOR/SLT/illegal -> DONE; MUL -> MUL; DIV -> DIV.
REQ-023 Single-cycle ops: out_valid asserts on the cycle after the handshake, giving a latency of 1.
REQ-024 ADD/SUB wrap modulo 2^XLEN; SLT is a signed compare, with result 1 or 0 zero-extended.
REQ-025 MUL: iterative shift-add, one bit per cycle, XLEN iterations then DONE, giving a latency of XLEN+1; result is the low XLEN bits of the product.
REQ-026 DIV: signed restoring divide, one quotient bit per cycle, XLEN iterations then DONE, giving a latency of XLEN+1.
REQ-027 DIV divide-by-zero: result all ones, illegal 0.
REQ-028 DIV overflow (most-negative / -1): result is the most-negative value.
REQ-029 Illegal: result 0, illegal 1, alu_ctrl 1111.
REQ-030 DONE: out_valid, result, alu_ctrl and illegal are held stable until out_ready; on out_ready the unit goes to IDLE.
REQ-031 No new request is accepted in the cycle of the out_ready handshake; the minimum issue interval is 2 cycles.
REQ-032 in_valid while not in IDLE is ignored and does not stall internal iteration.

Reset
REQ-033 rst has priority over all other inputs; the next state is IDLE.
REQ-034 Reset values: in_ready 1, out_valid 0, result 0, alu_ctrl 0000, illegal 0, iteration counter 0.
REQ-035 Reset during MUL, DIV or DONE aborts the operation; the pending result is discarded and never presented.

Configuration
REQ-036 Macro ALU_MDU_DIV_EN: when defined, the DIV datapath and DIV state are built.
REQ-037 When ALU_MDU_DIV_EN is undefined, {100,0000001} decodes as illegal, no divider logic exists, and the latency is 1.

Verification
REQ-038 XLEN=32, R-type ADD, op_a=0xFFFFFFFF, op_b=1 -> out_valid 1 cycle after handshake, result 0x00000000, alu_ctrl 0010.
REQ-039 I-type SLT (func3 010), op_a=0xFFFFFFFE (-2), op_b=0x00000003 -> result 1, alu_ctrl 0111.
REQ-040 MUL, op_a=0x00010003, op_b=0x00020005 -> out_valid exactly 33 cycles after handshake, result 0x000B000F.
REQ-041 ALU_MDU_DIV_EN defined: DIV -7/2 -> result 0xFFFFFFFD after 33 cycles; DIV 5/0 -> result 0xFFFFFFFF; 0x80000000/0xFFFFFFFF -> result 0x80000000.
REQ-042 R-type func3 000, func7 0100001 -> result 0, illegal 1, alu_ctrl 1111; with out_ready low for 5 cycles, outputs are held stable and in_ready stays 0.
REQ-043 Reset asserted 10 cycles into a MUL -> next cycle in_ready 1, out_valid 0, result 0; a new ADD then completes normally.
